// File: rtl/cart_004_mapper.sv
// cart_004_mapper
// MMC3 (mapper 4) control core. It holds the CPU-visible register file and from it
// generates PRG/CHR bank addresses, nametable mirroring and the A12-driven scanline IRQ.
//
// Ports
//   i_clk_cpu       single clock; every input is synchronous to it
//   i_rst_n         synchronous reset, active low
//   i_cpu_addr      CPU address A14..A0
//   i_cpu_data      CPU write data
//   i_cpu_rw        1 = read, 0 = write
//   i_romsel        1 = CPU access in $8000-$FFFF
//   i_ppu_addr      PPU address, already synchronised to i_clk_cpu
//   i_ppu_wr        PPU write strobe
//   o_prg_rom_addr  PRG ROM byte address (combinational)
//   o_prg_ram_cs    PRG RAM select ($6000-$7FFF while RAM is enabled)
//   o_prg_ram_we    PRG RAM write enable
//   o_chr_addr      CHR byte address (combinational)
//   o_chr_we        CHR write enable (PPU write below $2000)
//   o_ciram_ce      CIRAM select (PPU A13)
//   o_ciram_a10     CIRAM A10 after mirroring
//   o_irq           registered level IRQ request, active high
module cart_004_mapper #(
  parameter int PRG_ROM_DEPTH = 19,
  parameter int CHR_ROM_DEPTH = 18,
  parameter int A12_FILTER    = 3,
  parameter int IRQ_ALT_REV   = 0
) (
  input  logic                     i_clk_cpu,
  input  logic                     i_rst_n,
  input  logic [14:0]              i_cpu_addr,
  input  logic [7:0]               i_cpu_data,
  input  logic                     i_cpu_rw,
  input  logic                     i_romsel,
  input  logic [13:0]              i_ppu_addr,
  input  logic                     i_ppu_wr,
  output logic [PRG_ROM_DEPTH-1:0] o_prg_rom_addr,
  output logic                     o_prg_ram_cs,
  output logic                     o_prg_ram_we,
  output logic [CHR_ROM_DEPTH-1:0] o_chr_addr,
  output logic                     o_chr_we,
  output logic                     o_ciram_ce,
  output logic                     o_ciram_a10,
  output logic                     o_irq
);

  localparam int PB = PRG_ROM_DEPTH - 13;
  localparam int CB = CHR_ROM_DEPTH - 10;
  localparam int LW = $clog2(A12_FILTER + 1);
  localparam logic [LW-1:0] FILT = LW'(A12_FILTER);

  logic [2:0]    r_bank_sel;
  logic          r_prg_mode;
  logic          r_chr_inv;
  logic [7:0]    r_bank [8];
  logic          r_mirror;
  logic          r_ram_en;
  logic          r_ram_wp;
  logic [7:0]    r_irq_latch;
  logic [7:0]    r_irq_cnt;
  logic          r_reload;
  logic          r_irq_en;
  logic          r_irq;
  logic [LW-1:0] r_low_cnt;
  logic          r_wr_d;

  logic          w_strobe;
  logic          w_wr;
  logic [2:0]    w_reg;
  logic          w_c001;
  logic          w_clock;
  logic          w_reload_path;
  logic [7:0]    w_cnt_next;
  logic          w_irq_hit;
  logic [PB-1:0] w_prg_bank;
  logic [PB-1:0] w_last;
  logic [PB-1:0] w_r6;
  logic [PB-1:0] w_r7;
  logic [2:0]    w_chr_slot;
  logic [7:0]    w_chr_bank8;

  // Only the first cycle of a CPU write strobe counts; a held strobe is ignored.
  assign w_strobe = i_romsel && !i_cpu_rw;
  assign w_wr     = w_strobe && !r_wr_d;
  assign w_reg    = {i_cpu_addr[14:13], i_cpu_addr[0]};
  assign w_c001   = w_wr && (w_reg == 3'b101);

  // low_cnt is cleared whenever A12 is high, so reaching the threshold also implies
  // A12 was low on the previous cycle; a high A12 here is therefore a filtered rise.
  assign w_clock = i_ppu_addr[12] && (r_low_cnt == FILT);

  // Counter step and IRQ condition for a scanline clock. The alternate revision only
  // fires on a real 1 -> 0 decrement, never on a reload.
  always_comb begin
    w_reload_path = (r_irq_cnt == 8'd0) || r_reload;
    w_cnt_next    = w_reload_path ? r_irq_latch : (r_irq_cnt - 8'd1);
    if (IRQ_ALT_REV == 0)
      w_irq_hit = r_irq_en && (w_cnt_next == 8'd0);
    else
      w_irq_hit = r_irq_en && !w_reload_path && (r_irq_cnt == 8'd1);
  end

  // PRG bank per 8 KB slot; the two top bits of R6/R7 never reach the bank field.
  always_comb begin
    w_last = '1;
    w_r6   = PB'(r_bank[6][5:0]);
    w_r7   = PB'(r_bank[7][5:0]);
    case ({r_prg_mode, i_cpu_addr[14:13]})
      3'b000:  w_prg_bank = w_r6;
      3'b001:  w_prg_bank = w_r7;
      3'b010:  w_prg_bank = w_last - PB'(1);
      3'b100:  w_prg_bank = w_last - PB'(1);
      3'b101:  w_prg_bank = w_r7;
      3'b110:  w_prg_bank = w_r6;
      default: w_prg_bank = w_last;
    endcase
  end

  assign o_prg_rom_addr = {w_prg_bank, i_cpu_addr[12:0]};

  // CHR bank per 1 KB slot; chr_inv swaps the 2 KB and 1 KB halves of the pattern space.
  always_comb begin
    w_chr_slot = i_ppu_addr[12:10] ^ {r_chr_inv, 2'b00};
    case (w_chr_slot)
      3'd0, 3'd1: w_chr_bank8 = {r_bank[0][7:1], i_ppu_addr[10]};
      3'd2, 3'd3: w_chr_bank8 = {r_bank[1][7:1], i_ppu_addr[10]};
      3'd4:       w_chr_bank8 = r_bank[2];
      3'd5:       w_chr_bank8 = r_bank[3];
      3'd6:       w_chr_bank8 = r_bank[4];
      default:    w_chr_bank8 = r_bank[5];
    endcase
  end

  assign o_chr_addr   = {CB'(w_chr_bank8), i_ppu_addr[9:0]};
  assign o_chr_we     = i_ppu_wr && !i_ppu_addr[13];
  assign o_ciram_ce   = i_ppu_addr[13];
  assign o_ciram_a10  = r_mirror ? i_ppu_addr[11] : i_ppu_addr[10];
  assign o_prg_ram_cs = !i_romsel && (i_cpu_addr[14:13] == 2'b11) && r_ram_en;
  assign o_prg_ram_we = o_prg_ram_cs && !i_cpu_rw && !r_ram_wp;
  assign o_irq        = r_irq;

  // Register file, A12 filter and IRQ counter. The CPU write cases sit after the
  // scanline update so that an $E000 write overrides an IRQ set in the same cycle;
  // a $C001 write suppresses the scanline update entirely.
  always_ff @(posedge i_clk_cpu) begin
    if (!i_rst_n) begin
      r_bank_sel  <= 3'd0;
      r_prg_mode  <= 1'b0;
      r_chr_inv   <= 1'b0;
      r_bank[0]   <= 8'd0;
      r_bank[1]   <= 8'd2;
      r_bank[2]   <= 8'd4;
      r_bank[3]   <= 8'd5;
      r_bank[4]   <= 8'd6;
      r_bank[5]   <= 8'd7;
      r_bank[6]   <= 8'd0;
      r_bank[7]   <= 8'd1;
      r_mirror    <= 1'b0;
      r_ram_en    <= 1'b1;
      r_ram_wp    <= 1'b0;
      r_irq_latch <= 8'd0;
      r_irq_cnt   <= 8'd0;
      r_reload    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_low_cnt   <= '0;
      r_wr_d      <= 1'b0;
    end else begin
      r_wr_d <= w_strobe;

      if (i_ppu_addr[12])
        r_low_cnt <= '0;
      else if (r_low_cnt != FILT)
        r_low_cnt <= r_low_cnt + LW'(1);

      if (w_clock && !w_c001) begin
        r_irq_cnt <= w_cnt_next;
        r_reload  <= 1'b0;
        if (w_irq_hit)
          r_irq <= 1'b1;
      end

      if (w_wr) begin
        case (w_reg)
          3'b000: begin
            r_bank_sel <= i_cpu_data[2:0];
            r_prg_mode <= i_cpu_data[6];
            r_chr_inv  <= i_cpu_data[7];
          end
          3'b001: r_bank[r_bank_sel] <= i_cpu_data;
          3'b010: r_mirror <= i_cpu_data[0];
          3'b011: begin
            r_ram_en <= i_cpu_data[7];
            r_ram_wp <= i_cpu_data[6];
          end
          3'b100: r_irq_latch <= i_cpu_data;
          3'b101: begin
            r_irq_cnt <= 8'd0;
            r_reload  <= 1'b1;
          end
          3'b110: begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
          end
          default: r_irq_en <= 1'b1;
        endcase
      end
    end
  end

endmodule
